// File: rtl/cpu_pkg.sv
// Shared encodings for the control unit and the downstream 16-bit ALU:
// instruction opcodes, ALU operation codes and the sequencer state type.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PASS = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LSH  = 4'h4;
  localparam logic [3:0] OP_RSH  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_MVR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JMPZ = 4'h9;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [2:0] ALU_HOLD = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_LSH  = 3'd4;
  localparam logic [2:0] ALU_RSH  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH2,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: maps the IR opcode nibble to ALU operation,
// datapath load enables and instruction-class flags.
module cu_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [3:0]     opcode,
  output logic [OPW-1:0] alu_op,
  output logic           ld_ac,
  output logic           ld_r,
  output logic           two_byte,
  output logic           is_end,
  output logic           illegal
);

  always_comb begin
    alu_op   = OPW'(ALU_HOLD);
    ld_ac    = 1'b0;
    ld_r     = 1'b0;
    two_byte = 1'b0;
    is_end   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_PASS: begin alu_op = OPW'(ALU_PASS); ld_ac = 1'b1; end
      OP_ADD:  begin alu_op = OPW'(ALU_ADD);  ld_ac = 1'b1; end
      OP_SUB:  begin alu_op = OPW'(ALU_SUB);  ld_ac = 1'b1; end
      OP_LSH:  begin alu_op = OPW'(ALU_LSH);  ld_ac = 1'b1; end
      OP_RSH:  begin alu_op = OPW'(ALU_RSH);  ld_ac = 1'b1; end
      OP_OR:   begin alu_op = OPW'(ALU_OR);   ld_ac = 1'b1; end
      OP_MVR:  ld_r = 1'b1;
      OP_JMP, OP_JMPZ: two_byte = 1'b1;
      OP_END:  is_end = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/sequence FSM driving the 16-bit ALU. Holds the FSM, PC and IR.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes halt and raise a sticky err.
module control_unit
  import cpu_pkg::*;
#(
  parameter int IW  = 8,
  parameter int AW  = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [AW-1:0]  instr_addr,
  output logic           instr_rd,
  input  logic           instr_valid,
  input  logic [IW-1:0]  instr_data,
  input  logic           z,
  output logic [OPW-1:0] alu_op,
  output logic           ld_ac,
  output logic           ld_r,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_t          state, state_nx;
  logic [AW-1:0]   pc, pc_nx;
  logic [IW-1:0]   ir, ir_nx;
  logic [3:0]      opcode;
  logic [OPW-1:0]  dec_alu_op;
  logic            dec_ld_ac, dec_ld_r, dec_two_byte, dec_is_end, dec_illegal;

  // Reserved low nibble is never looked at.
  assign opcode = ir[IW-1 -: 4];

  cu_decode #(.OPW(OPW)) u_decode (
    .opcode   (opcode),
    .alu_op   (dec_alu_op),
    .ld_ac    (dec_ld_ac),
    .ld_r     (dec_ld_r),
    .two_byte (dec_two_byte),
    .is_end   (dec_is_end),
    .illegal  (dec_illegal)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  logic err_q, err_nx;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      done  <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      done  <= (state_nx == S_HALT) && (state != S_HALT);
`ifdef CU_ILLEGAL_TRAP_EN
      err_q <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    instr_rd   = 1'b0;
    instr_addr = pc;
    alu_op     = OPW'(ALU_HOLD);
    ld_ac      = 1'b0;
    ld_r       = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    err_nx     = err_q;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
`ifdef CU_ILLEGAL_TRAP_EN
          err_nx   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        instr_rd = 1'b1;
        if (instr_valid) begin
          ir_nx    = instr_data;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_two_byte)    state_nx = S_FETCH2;
        else if (dec_is_end) state_nx = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
        else if (dec_illegal) begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end
`endif
        else                 state_nx = S_EXEC;
      end
      S_FETCH2: begin
        instr_rd   = 1'b1;
        instr_addr = pc + AW'(1);
        if (instr_valid) begin
          // JMPZ not taken skips both bytes; z is sampled alongside the target byte.
          if (opcode == OP_JMPZ && !z) pc_nx = pc + AW'(2);
          else                         pc_nx = AW'(instr_data);
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op   = dec_alu_op;
        state_nx = S_WB;
      end
      S_WB: begin
        alu_op   = dec_alu_op;
        ld_ac    = dec_ld_ac;
        ld_r     = dec_ld_r;
        pc_nx    = pc + AW'(1);
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: zero-wait and wait-state instruction memory,
// branches, PC wrap, illegal opcodes and asynchronous reset.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst_n, start, instr_rd, instr_valid, z;
  logic [7:0] instr_addr, instr_data;
  logic [2:0] alu_op;
  logic       ld_ac, ld_r, busy, done, err;

  logic [7:0]  mem [0:255];
  int unsigned wait_n = 0;
  int unsigned cnt = 0;
  int          checks = 0;
  int          errors = 0;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  control_unit #(.IW(8), .AW(8), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr),
    .instr_rd(instr_rd), .instr_valid(instr_valid), .instr_data(instr_data),
    .z(z), .alu_op(alu_op), .ld_ac(ld_ac), .ld_r(ld_r), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign instr_valid = instr_rd && (cnt >= wait_n);
  assign instr_data  = mem[instr_addr];
  always @(posedge clk) begin
    if (instr_rd && !instr_valid) cnt <= cnt + 1;
    else                          cnt <= 0;
  end

  // Packed view: {alu_op, ld_ac, ld_r, instr_rd, busy, done, err, instr_addr}
  function automatic logic [16:0] ev(input logic [2:0] op, input logic ac, input logic r,
                                     input logic rd, input logic bz, input logic dn,
                                     input logic er, input logic [7:0] a);
    return {op, ac, r, rd, bz, dn, er, a};
  endfunction

  function automatic logic [16:0] obs();
    return {alu_op, ld_ac, ld_r, instr_rd, busy, done, err, instr_addr};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tc(input string tag, input logic [16:0] e);
    step();
    chk(tag, obs(), e);
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_idle", obs(), ev(0,0,0,0,0,0,0,8'h00));
  endtask

  logic [7:0] lp_prog [0:5];
  logic [2:0] lp_op   [0:4];
  logic       lp_ac   [0:4];
  logic       lp_r    [0:4];

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; z = 1'b0;
    clr_mem();
    step(); step();
    chk("reset_hold", obs(), ev(0,0,0,0,0,0,0,8'h00));
    rst_n = 1'b1; start = 1'b0;
    tc("idle_after_rel", ev(0,0,0,0,0,0,0,8'h00));

    // PASS, ADD, END with zero-wait memory
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'hF0;
    go();
    chk("alu_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("alu_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("alu_e0", ev(1,0,0,0,1,0,0,8'h00));
    tc("alu_w0", ev(1,1,0,0,1,0,0,8'h00));
    tc("alu_f1", ev(0,0,0,1,1,0,0,8'h01));
    tc("alu_d1", ev(0,0,0,0,1,0,0,8'h01));
    tc("alu_e1", ev(2,0,0,0,1,0,0,8'h01));
    tc("alu_w1", ev(2,1,0,0,1,0,0,8'h01));
    tc("alu_f2", ev(0,0,0,1,1,0,0,8'h02));
    tc("alu_d2", ev(0,0,0,0,1,0,0,8'h02));
    tc("alu_halt", ev(0,0,0,0,0,1,0,8'h02));
    tc("alu_halt2", ev(0,0,0,0,0,0,0,8'h02));

    // Remaining ALU ops and MVR, reserved bits set; start held high must be ignored
    lp_prog = '{8'h3C, 8'h41, 8'h5F, 8'h62, 8'h7A, 8'hF0};
    lp_op   = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    lp_ac   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    lp_r    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clr_mem();
    for (int i = 0; i < 6; i++) mem[i] = lp_prog[i];
    go();
    chk("lp_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tc($sformatf("lp_d%0d", i), ev(0,0,0,0,1,0,0,8'(i)));
      tc($sformatf("lp_e%0d", i), ev(lp_op[i],0,0,0,1,0,0,8'(i)));
      tc($sformatf("lp_w%0d", i), ev(lp_op[i],lp_ac[i],lp_r[i],0,1,0,0,8'(i)));
      tc($sformatf("lp_f%0d", i+1), ev(0,0,0,1,1,0,0,8'(i+1)));
    end
    start = 1'b0;
    tc("lp_d5", ev(0,0,0,0,1,0,0,8'h05));
    tc("lp_halt", ev(0,0,0,0,0,1,0,8'h05));

    // Three wait states per fetch: rd and address held while stalled
    clr_mem();
    mem[0] = 8'h20; mem[1] = 8'hF0;
    wait_n = 3;
    go();
    chk("ws_f0_0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    for (int i = 1; i < 4; i++) tc($sformatf("ws_f0_%0d", i), ev(0,0,0,1,1,0,0,8'h00));
    tc("ws_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("ws_e0", ev(2,0,0,0,1,0,0,8'h00));
    tc("ws_w0", ev(2,1,0,0,1,0,0,8'h00));
    for (int i = 0; i < 4; i++) tc($sformatf("ws_f1_%0d", i), ev(0,0,0,1,1,0,0,8'h01));
    tc("ws_d1", ev(0,0,0,0,1,0,0,8'h01));
    tc("ws_halt", ev(0,0,0,0,0,1,0,8'h01));
    wait_n = 0;

    // JMPZ taken / not taken
    clr_mem();
    mem[0] = 8'h90; mem[1] = 8'h05; mem[2] = 8'hF0; mem[5] = 8'hF0;
    z = 1'b1;
    go();
    chk("jz1_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("jz1_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("jz1_f2", ev(0,0,0,1,1,0,0,8'h01));
    tc("jz1_tgt", ev(0,0,0,1,1,0,0,8'h05));
    tc("jz1_d5", ev(0,0,0,0,1,0,0,8'h05));
    tc("jz1_halt", ev(0,0,0,0,0,1,0,8'h05));
    z = 1'b0;
    go();
    chk("jz0_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("jz0_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("jz0_f2", ev(0,0,0,1,1,0,0,8'h01));
    tc("jz0_skip", ev(0,0,0,1,1,0,0,8'h02));
    tc("jz0_d2", ev(0,0,0,0,1,0,0,8'h02));
    tc("jz0_halt", ev(0,0,0,0,0,1,0,8'h02));

    // JMP 0x00 from 0xFE loops back to 0
    clr_mem();
    mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h00;
    go();
    chk("jmp_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("jmp_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("jmp_f2a", ev(0,0,0,1,1,0,0,8'h01));
    tc("jmp_fe", ev(0,0,0,1,1,0,0,8'hFE));
    tc("jmp_dfe", ev(0,0,0,0,1,0,0,8'hFE));
    tc("jmp_f2b", ev(0,0,0,1,1,0,0,8'hFF));
    tc("jmp_loop", ev(0,0,0,1,1,0,0,8'h00));
    do_reset();

    // JMPZ not taken at 0xFE: PC+2 wraps to 0
    mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h33;
    go();
    chk("jzw_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("jzw_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("jzw_f2a", ev(0,0,0,1,1,0,0,8'h01));
    tc("jzw_fe", ev(0,0,0,1,1,0,0,8'hFE));
    tc("jzw_dfe", ev(0,0,0,0,1,0,0,8'hFE));
    tc("jzw_f2b", ev(0,0,0,1,1,0,0,8'hFF));
    tc("jzw_wrap", ev(0,0,0,1,1,0,0,8'h00));
    do_reset();

    // NOP at 0xFF wraps the next fetch to 0x00
    mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    go();
    chk("wr_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("wr_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("wr_f2", ev(0,0,0,1,1,0,0,8'h01));
    tc("wr_fff", ev(0,0,0,1,1,0,0,8'hFF));
    tc("wr_dff", ev(0,0,0,0,1,0,0,8'hFF));
    tc("wr_eff", ev(0,0,0,0,1,0,0,8'hFF));
    tc("wr_wff", ev(0,0,0,0,1,0,0,8'hFF));
    tc("wr_f00", ev(0,0,0,1,1,0,0,8'h00));
    do_reset();

    // Async reset during EXEC drops alu_op before any load
    clr_mem();
    mem[0] = 8'h20; mem[1] = 8'hF0;
    go();
    tc("ra_d0", ev(0,0,0,0,1,0,0,8'h00));
    tc("ra_e0", ev(2,0,0,0,1,0,0,8'h00));
    #2 rst_n = 1'b0;
    #1 chk("ra_abort", obs(), ev(0,0,0,0,0,0,0,8'h00));
    step();
    chk("ra_held", obs(), ev(0,0,0,0,0,0,0,8'h00));
    rst_n = 1'b1;

    // Illegal opcode 0xA0
    mem[0] = 8'hA0; mem[1] = 8'hF0;
    go();
    chk("il_f0", obs(), ev(0,0,0,1,1,0,0,8'h00));
    tc("il_d0", ev(0,0,0,0,1,0,0,8'h00));
    if (TRAP) begin
      tc("il_trap", ev(0,0,0,0,0,1,1,8'h00));
      tc("il_sticky", ev(0,0,0,0,0,0,1,8'h00));
      go();
      chk("il_clear", obs(), ev(0,0,0,1,1,0,0,8'h00));
    end else begin
      tc("il_e0", ev(0,0,0,0,1,0,0,8'h00));
      tc("il_w0", ev(0,0,0,0,1,0,0,8'h00));
      tc("il_f1", ev(0,0,0,1,1,0,0,8'h01));
      tc("il_d1", ev(0,0,0,0,1,0,0,8'h01));
      tc("il_halt", ev(0,0,0,0,0,1,0,8'h01));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction fetch/decode/sequence FSM directly upstream of the 16-bit ALU.
- Fetches byte-wide instructions from instruction memory through a valid handshake.
- Drives the ALU's 3-bit `operation` code and the datapath load enables.
- Takes the ALU's registered `z` flag to resolve conditional jumps.

Parameters:
- IW, 8, instruction word width in bits.
- AW, 8, instruction address (PC) width in bits.
- OPW, 3, ALU operation code width; must match the ALU `operation` port.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; starts execution from address 0 when idle.
- instr_addr  out  AW  instruction memory address (PC, or PC+1 for an operand byte).
- instr_rd  out  1  read request; held high until instr_valid.
- instr_valid  in  1  instruction memory has data on instr_data this cycle.
- instr_data  in  IW  instruction byte.
- z  in  1  ALU zero flag (registered inside the ALU).
- alu_op  out  OPW  to ALU `operation`; 0 = hold.
- ld_ac  out  1  accumulator load from ALU `C`, one cycle.
- ld_r  out  1  register R load from accumulator, one cycle.
- busy  out  1  high from accepted start until HALT.
- done  out  1  one-cycle pulse on entering HALT.
- err  out  1  illegal opcode flag; only with CU_ILLEGAL_TRAP_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, PC=0, IR=0, alu_op=0, ld_ac=0, ld_r=0, instr_rd=0, busy=0, done=0, err=0.
- Reset asserted mid-instruction aborts it immediately; no partial load is issued.
- Instruction format: [7:4] opcode; [3:0] reserved, must be ignored.
- Opcodes:
  - 0 NOP
  - 1 PASS (alu_op=1)
  - 2 ADD (2)
  - 3 SUB (3)
  - 4 LSH (4)
  - 5 RSH (5)
  - 6 OR (6)
  - 7 MVR (ld_r only)
  - 8 JMP (two-byte; target in second byte)
  - 9 JMPZ (two-byte)
  - F END
  - A–E illegal.
- States: IDLE, FETCH, DECODE, FETCH2, EXEC, WB, HALT.
  - IDLE: start=1 -> FETCH, PC=0, busy=1. start is ignored in every other state.
  - FETCH: instr_rd=1, instr_addr=PC. On instr_valid: IR<=instr_data -> DECODE. No timeout; waits indefinitely.
  - DECODE (1 cycle):
    - JMP/JMPZ -> FETCH2.
    - END -> HALT.
    - All other opcodes -> EXEC.
  - FETCH2: instr_rd=1, instr_addr=PC+1, wait for instr_valid.
    - JMP: PC<=instr_data.
    - JMPZ: PC<=instr_data if z=1, else PC<=PC+2. z is sampled in the same cycle instr_valid is high.
    - Then -> FETCH.
  - EXEC (1 cycle): alu_op driven from the opcode; NOP/MVR drive alu_op=0. -> WB.
  - WB (1 cycle): alu_op held. ld_ac=1 for opcodes 1–6; ld_r=1 for MVR. PC<=PC+1. -> FETCH.
  - HALT: done=1 for the entry cycle only, busy=0, alu_op=0. Stays until start=1 -> FETCH with PC=0.
- Timing:
  - alu_op is stable for exactly the two cycles EXEC+WB, so the combinational ALU output is settled before ld_ac.
  - Single-byte ALU instruction latency: 4 cycles with zero-wait memory (FETCH, DECODE, EXEC, WB).
- PC arithmetic is modulo 2^AW: 0xFF+1 wraps to 0x00; PC+2 from 0xFE gives 0x00.
- instr_rd is never high outside FETCH/FETCH2.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE -> HALT, err=1 (sticky until reset or the next start), done pulses.
- Undefined: illegal opcodes execute as NOP (PC+1); err is tied 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_END);
  - ALU operation codes (ALU_PASS=1 … ALU_OR=6, ALU_HOLD=0), shared with the ALU;
  - the state encoding.
- One sub-module, cu_decode: combinational IR opcode -> {alu_op, ld_ac, ld_r, two_byte, is_end, illegal}.
- control_unit holds only the FSM, PC and IR.

Test Plan:
- Reset/idle: rst_n low with start=1 -> all outputs 0, instr_rd=0. After release, start pulse -> instr_rd=1 with instr_addr=0 the next cycle.
- ALU sequence with zero-wait memory, program {0x10,0x20,0xF0}:
  - alu_op=1 for 2 cycles then ld_ac pulse; alu_op=2 for 2 cycles then ld_ac pulse;
  - done pulse 4 cycles later; busy falls.
- Wait states: instr_valid delayed 3 cycles per fetch -> IR/PC unchanged and instr_rd held throughout; ADD completes 3 cycles later.
- Branch: program {0x90,0x05,…}:
  - with z=1 -> next instr_addr=0x05;
  - with z=0 -> next instr_addr=0x02.
  - JMP 0x00 from address 0xFE loops to 0.
- Wrap: NOP at 0xFF -> next fetch address 0x00.
- Illegal opcode 0xA0:
  - with CU_ILLEGAL_TRAP_EN -> err=1, HALT;
  - without -> PC advances to 1, err stays 0.
